// File: rtl/boarding_control.sv
// ---------------------------------------------------------------------------
// boarding_control
// Elevator car boarding sequencer. After the car arrives at a floor the door
// is held open while passengers board. An idle door timer starts closing,
// occupancy at or above MAX_PASSENGERS holds the door open with the alarm on,
// an entry during closing reopens the door, and the car reports it may move
// once the door has been closed for DOOR_CLOSE_CYCLES cycles.
//
// Ports
//   i_clk                     system clock, rising edge
//   i_reset                   asynchronous active-high reset
//   i_arrive                  pulse: car stopped at a floor, start boarding
//   i_enter_pulse             pulse per passenger entering
//   i_exit_pulse              pulse per passenger leaving
//   i_close_request           door-close button (level)
//   i_depart_ack              pulse: motion controller accepted departure
//   o_door_open               door commanded open (BOARDING, OVERLOAD)
//   o_alarm                   overload buzzer (OVERLOAD)
//   o_depart_ready            door closed, car may move (READY)
//   o_weight_limit_exceeded   passenger count >= MAX_PASSENGERS
//   o_passenger_count         current occupancy
//   o_state                   FSM state encoding, for debug
// ---------------------------------------------------------------------------
module boarding_control #(
    parameter int MAX_PASSENGERS    = 5,
    parameter int DOOR_OPEN_CYCLES  = 8,
    parameter int DOOR_CLOSE_CYCLES = 4,
    parameter int COUNT_W           = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_arrive,
    input  logic               i_enter_pulse,
    input  logic               i_exit_pulse,
    input  logic               i_close_request,
    input  logic               i_depart_ack,
    output logic               o_door_open,
    output logic               o_alarm,
    output logic               o_depart_ready,
    output logic               o_weight_limit_exceeded,
    output logic [COUNT_W-1:0] o_passenger_count,
    output logic [2:0]         o_state
);

    localparam int OPEN_W  = (DOOR_OPEN_CYCLES  > 1) ? $clog2(DOOR_OPEN_CYCLES)  : 1;
    localparam int CLOSE_W = (DOOR_CLOSE_CYCLES > 1) ? $clog2(DOOR_CLOSE_CYCLES) : 1;

    localparam logic [OPEN_W-1:0]  OPEN_RELOAD  = OPEN_W'(DOOR_OPEN_CYCLES - 1);
    localparam logic [CLOSE_W-1:0] CLOSE_RELOAD = CLOSE_W'(DOOR_CLOSE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_LIMIT  = COUNT_W'(MAX_PASSENGERS);
    localparam logic [COUNT_W-1:0] COUNT_SAT    = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BOARDING = 3'd1,
        OVERLOAD = 3'd2,
        CLOSING  = 3'd3,
        READY    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [COUNT_W-1:0]   r_count;
    logic [COUNT_W-1:0]   w_count_next;
    logic [OPEN_W-1:0]    r_door_timer;
    logic [OPEN_W-1:0]    w_door_timer_next;
    logic [CLOSE_W-1:0]   r_close_timer;
    logic [CLOSE_W-1:0]   w_close_timer_next;
    logic                 w_counting;
    logic                 w_pulse;
    logic                 w_over_next;

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_door_timer  <= '0;
            r_close_timer <= '0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_door_timer  <= w_door_timer_next;
            r_close_timer <= w_close_timer_next;
        end
    end

    // Occupancy update and next-state logic
    always_comb begin
        w_counting         = (r_state == BOARDING) || (r_state == OVERLOAD) ||
                             (r_state == CLOSING);
        w_pulse            = i_enter_pulse || i_exit_pulse;
        w_count_next       = r_count;
        w_state_next       = r_state;
        w_door_timer_next  = r_door_timer;
        w_close_timer_next = r_close_timer;

        // Simultaneous enter and exit cancel out; both ends saturate.
        if (w_counting) begin
            if (i_enter_pulse && !i_exit_pulse && (r_count != COUNT_SAT)) begin
                w_count_next = r_count + COUNT_W'(1);
            end else if (i_exit_pulse && !i_enter_pulse && (r_count != '0)) begin
                w_count_next = r_count - COUNT_W'(1);
            end
        end

        // Overload decisions look at the occupancy after this cycle's pulses,
        // so the alarm tracks the count without a one-cycle lag.
        w_over_next = (w_count_next >= COUNT_LIMIT);

        case (r_state)
            IDLE: begin
                if (i_arrive) begin
                    w_state_next      = BOARDING;
                    w_door_timer_next = OPEN_RELOAD;
                end
            end
            BOARDING: begin
                if (w_pulse) begin
                    w_door_timer_next = OPEN_RELOAD;
                end else if (r_door_timer != '0) begin
                    w_door_timer_next = r_door_timer - OPEN_W'(1);
                end
                if (w_over_next) begin
                    w_state_next = OVERLOAD;
                end else if ((r_door_timer == '0) || i_close_request) begin
                    w_state_next       = CLOSING;
                    w_close_timer_next = CLOSE_RELOAD;
                end
            end
            OVERLOAD: begin
                // close_request is deliberately ignored while overloaded
                if (!w_over_next) begin
                    w_state_next      = BOARDING;
                    w_door_timer_next = OPEN_RELOAD;
                end
            end
            CLOSING: begin
                if (i_enter_pulse) begin
                    w_state_next      = BOARDING;
                    w_door_timer_next = OPEN_RELOAD;
                end else if (r_close_timer == '0) begin
                    w_state_next = READY;
                end else begin
                    w_close_timer_next = r_close_timer - CLOSE_W'(1);
                end
            end
            READY: begin
                if (i_depart_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Moore output decodes
    assign o_door_open             = (r_state == BOARDING) || (r_state == OVERLOAD);
    assign o_alarm                 = (r_state == OVERLOAD);
    assign o_depart_ready          = (r_state == READY);
    assign o_weight_limit_exceeded = (r_count >= COUNT_LIMIT);
    assign o_passenger_count       = r_count;
    assign o_state                 = r_state;

endmodule

// File: tb/tb_boarding_control.sv
module tb_boarding_control;

    localparam int MAXP   = 5;
    localparam int OPENC  = 8;
    localparam int CLOSEC = 4;
    localparam int CW     = 4;
    localparam int SAT    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arrive = 1'b0;
    logic          enter_pulse = 1'b0;
    logic          exit_pulse = 1'b0;
    logic          close_request = 1'b0;
    logic          depart_ack = 1'b0;
    logic          door_open;
    logic          alarm;
    logic          depart_ready;
    logic          wle;
    logic [CW-1:0] passenger_count;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;

    // Behavioural model: integer state number, occupancy and remaining times
    int m_state;
    int m_count;
    int m_open_left;
    int m_close_left;

    boarding_control #(
        .MAX_PASSENGERS(MAXP),
        .DOOR_OPEN_CYCLES(OPENC),
        .DOOR_CLOSE_CYCLES(CLOSEC),
        .COUNT_W(CW)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_arrive(arrive),
        .i_enter_pulse(enter_pulse),
        .i_exit_pulse(exit_pulse),
        .i_close_request(close_request),
        .i_depart_ack(depart_ack),
        .o_door_open(door_open),
        .o_alarm(alarm),
        .o_depart_ready(depart_ready),
        .o_weight_limit_exceeded(wle),
        .o_passenger_count(passenger_count),
        .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_count = 0; m_open_left = 0; m_close_left = 0;
    endtask

    task automatic model_step(input bit a, input bit e, input bit x, input bit c, input bit k);
        int n;
        n = m_count;
        if (m_state >= 1 && m_state <= 3) begin
            if (e && !x) n = (m_count + 1 > SAT) ? SAT : m_count + 1;
            if (x && !e) n = (m_count == 0) ? 0 : m_count - 1;
        end
        case (m_state)
            0: if (a) begin m_state = 1; m_open_left = OPENC - 1; end
            1: begin
                if (n >= MAXP) m_state = 2;
                else if (m_open_left == 0 || c) begin m_state = 3; m_close_left = CLOSEC - 1; end
                else if (e || x) m_open_left = OPENC - 1;
                else m_open_left = m_open_left - 1;
            end
            2: if (n < MAXP) begin m_state = 1; m_open_left = OPENC - 1; end
            3: begin
                if (e) begin m_state = 1; m_open_left = OPENC - 1; end
                else if (m_close_left == 0) m_state = 4;
                else m_close_left = m_close_left - 1;
            end
            default: if (k) m_state = 0;
        endcase
        m_count = n;
    endtask

    // Drive one clock cycle of inputs, advance the model, sample 1 ns later
    task automatic step(input bit a, input bit e, input bit x, input bit c, input bit k);
        arrive = a; enter_pulse = e; exit_pulse = x; close_request = c; depart_ack = k;
        @(posedge clk);
        model_step(a, e, x, c, k);
        #1;
        arrive = 0; enter_pulse = 0; exit_pulse = 0; close_request = 0; depart_ack = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({door_open, alarm, depart_ready, wle} !== 4'b0 || state !== 3'd0 || passenger_count !== '0) begin
            errors++;
            $display("FAIL reset_async got state=%0d count=%0d outs=%b%b%b%b required all 0",
                     state, passenger_count, door_open, alarm, depart_ready, wle);
        end
        apply_reset();
        step(0, 1, 0, 0, 0);
        checks++;
        if (state !== 3'd0 || passenger_count !== '0) begin
            errors++;
            $display("FAIL reset_idle_pulse got state=%0d count=%0d required 0/0", state, passenger_count);
        end
        $display("test_reset done: state=%0d count=%0d", state, passenger_count);
    endtask

    task automatic test_overload();
        apply_reset();
        step(1, 0, 0, 0, 0);
        checks++;
        if (state !== 3'd1 || door_open !== 1'b1) begin
            errors++;
            $display("FAIL ovl_arrive got state=%0d door=%b required 1/1", state, door_open);
        end
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        checks++;
        if (wle !== 1'b1 || passenger_count !== 4'd5 || state !== 3'd2 || alarm !== 1'b1 || door_open !== 1'b1) begin
            errors++;
            $display("FAIL ovl_enter5 got wle=%b count=%0d state=%0d alarm=%b door=%b required 1/5/2/1/1",
                     wle, passenger_count, state, alarm, door_open);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        checks++;
        if (state !== 3'd2 || alarm !== 1'b1) begin
            errors++;
            $display("FAIL ovl_close_ignored got state=%0d alarm=%b required 2/1", state, alarm);
        end
        step(0, 0, 1, 1, 0);
        checks++;
        if (state !== 3'd1 || alarm !== 1'b0 || passenger_count !== 4'd4 || wle !== 1'b0) begin
            errors++;
            $display("FAIL ovl_exit got state=%0d alarm=%b count=%0d wle=%b required 1/0/4/0",
                     state, alarm, passenger_count, wle);
        end
        $display("test_overload done: state=%0d count=%0d", state, passenger_count);
    endtask

    task automatic test_timeout();
        int closing_at;
        apply_reset();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        closing_at = 0;
        for (int i = 1; i <= 12 && closing_at == 0; i++) begin
            step(0, 0, 0, 0, 0);
            if (state === 3'd3) closing_at = i;
        end
        checks++;
        if (closing_at != OPENC) begin
            errors++;
            $display("FAIL timeout_open got closing after %0d cycles required %0d", closing_at, OPENC);
        end
        for (int i = 0; i < CLOSEC; i++) step(0, 0, 0, 0, 0);
        checks++;
        if (state !== 3'd4 || depart_ready !== 1'b1 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ready got state=%0d ready=%b door=%b required 4/1/0", state, depart_ready, door_open);
        end
        step(1, 1, 0, 0, 0);
        checks++;
        if (state !== 3'd4 || passenger_count !== 4'd2) begin
            errors++;
            $display("FAIL ready_ignore got state=%0d count=%0d required 4/2", state, passenger_count);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (state !== 3'd0 || passenger_count !== 4'd2 || depart_ready !== 1'b0) begin
            errors++;
            $display("FAIL depart got state=%0d count=%0d ready=%b required 0/2/0", state, passenger_count, depart_ready);
        end
        $display("test_timeout done: closing after %0d cycles, count=%0d", closing_at, passenger_count);
    endtask

    task automatic test_reopen();
        int closing_at;
        apply_reset();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        checks++;
        if (state !== 3'd1 || door_open !== 1'b1 || passenger_count !== 4'd1) begin
            errors++;
            $display("FAIL reopen got state=%0d door=%b count=%0d required 1/1/1", state, door_open, passenger_count);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        checks++;
        if (passenger_count !== 4'd1 || state !== 3'd1) begin
            errors++;
            $display("FAIL both_pulses got count=%0d state=%0d required 1/1", passenger_count, state);
        end
        closing_at = 0;
        for (int i = 1; i <= 12 && closing_at == 0; i++) begin
            step(0, 0, 0, 0, 0);
            if (state === 3'd3) closing_at = i;
        end
        checks++;
        if (closing_at != OPENC) begin
            errors++;
            $display("FAIL both_reload got closing after %0d cycles required %0d", closing_at, OPENC);
        end
        $display("test_reopen done: closing after %0d cycles", closing_at);
    endtask

    task automatic test_saturation();
        apply_reset();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        checks++;
        if (passenger_count !== 4'd0) begin
            errors++;
            $display("FAIL exit_at_zero got count=%0d required 0", passenger_count);
        end
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < CLOSEC; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        checks++;
        if (passenger_count !== 4'd0 || state !== 3'd0) begin
            errors++;
            $display("FAIL idle_pulses got count=%0d state=%0d required 0/0", passenger_count, state);
        end
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < SAT + 3; i++) step(0, 1, 0, 0, 0);
        checks++;
        if (passenger_count !== 4'(SAT) || state !== 3'd2) begin
            errors++;
            $display("FAIL enter_sat got count=%0d state=%0d required %0d/2", passenger_count, state, SAT);
        end
        $display("test_saturation done: count=%0d", passenger_count);
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
        checks++;
        if (state !== 3'd2 || passenger_count !== 4'd6) begin
            errors++;
            $display("FAIL pre_reset got state=%0d count=%0d required 2/6", state, passenger_count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({door_open, alarm, depart_ready, wle} !== 4'b0 || state !== 3'd0 || passenger_count !== '0) begin
            errors++;
            $display("FAIL async_reset got state=%0d count=%0d outs=%b%b%b%b required all 0",
                     state, passenger_count, door_open, alarm, depart_ready, wle);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
        checks++;
        if (state !== 3'd0 || door_open !== 1'b0 || passenger_count !== '0) begin
            errors++;
            $display("FAIL post_reset_quiet got state=%0d door=%b count=%0d required 0/0/0", state, door_open, passenger_count);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if (state !== 3'd1 || door_open !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_arrive got state=%0d door=%b required 1/1", state, door_open);
        end
        $display("test_async_reset done: state=%0d", state);
    endtask

    task automatic test_random();
        bit a, e, x, c, k;
        int errs_before;
        errs_before = errors;
        apply_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            a = ($urandom_range(7) == 0);
            e = ($urandom_range(3) == 0);
            x = ($urandom_range(4) == 0);
            c = ($urandom_range(9) == 0);
            k = ($urandom_range(3) == 0);
            step(a, e, x, c, k);
            checks++;
            if (state !== 3'(m_state)) begin
                errors++;
                $display("FAIL rand_state cyc=%0d got=%0d required=%0d", cyc, state, m_state);
            end
            checks++;
            if (passenger_count !== CW'(m_count)) begin
                errors++;
                $display("FAIL rand_count cyc=%0d got=%0d required=%0d", cyc, passenger_count, m_count);
            end
            checks++;
            if (door_open !== (m_state == 1 || m_state == 2)) begin
                errors++;
                $display("FAIL rand_door cyc=%0d got=%b model_state=%0d", cyc, door_open, m_state);
            end
            checks++;
            if (alarm !== (m_state == 2)) begin
                errors++;
                $display("FAIL rand_alarm cyc=%0d got=%b model_state=%0d", cyc, alarm, m_state);
            end
            checks++;
            if (depart_ready !== (m_state == 4)) begin
                errors++;
                $display("FAIL rand_ready cyc=%0d got=%b model_state=%0d", cyc, depart_ready, m_state);
            end
            checks++;
            if (wle !== (m_count >= MAXP)) begin
                errors++;
                $display("FAIL rand_wle cyc=%0d got=%b model_count=%0d", cyc, wle, m_count);
            end
            // Occasionally drain the car so low-occupancy behaviour keeps being exercised
            if (m_count > 10 && $urandom_range(3) == 0) apply_reset();
        end
        $display("test_random done: %0d new errors", errors - errs_before);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overload();
        test_timeout();
        test_reopen();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
